arb_wrr_pkt: RTL and testbench
==============================

ARB_WRR_PKT -- requirements
Module: arb_wrr_pkt

Interface
REQ-001 SHALL have parameter WIDTH, default 4, number of requesters (>=2).
REQ-002 SHALL have parameter PLD_WIDTH, default 32, payload bits per beat.
REQ-003 SHALL have parameter WGT_WIDTH, default 4, bits per requester weight.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port v_vld_s  input  WIDTH  per-requester beat valid.
REQ-007 SHALL have port v_rdy_s  output  WIDTH  per-requester beat ready, at most one bit set.
REQ-008 SHALL have port v_last_s  input  WIDTH  per-requester last-beat-of-packet flag.
REQ-009 SHALL have port v_pld_s  input  PLD_WIDTH x WIDTH (unpacked array)  per-requester payload.
REQ-010 SHALL have port v_weight  input  WIDTH*WGT_WIDTH  packed weights, requester i at bits [i*WGT_WIDTH +: WGT_WIDTH].
REQ-011 SHALL have port vld_m  output  1  master beat valid.
REQ-012 SHALL have port rdy_m  input  1  master ready.
REQ-013 SHALL have port pld_m  output  PLD_WIDTH  master payload.
REQ-014 SHALL have port last_m  output  1  master last flag.
REQ-015 SHALL have port gnt_id_m  output  $clog2(WIDTH)  index of requester that sourced current master beat.

Function
REQ-016 SHALL register vld_m/pld_m/last_m/gnt_id_m in a one-entry output stage; load = ~vld_m | rdy_m.
REQ-017 SHALL drive v_rdy_s[i] = load & (grant == i) & v_vld_s[i]; a beat transfers from i when v_vld_s[i] & v_rdy_s[i].
REQ-018 SHALL present an accepted beat on the master side the next cycle (latency 1) and sustain 1 beat/cycle when rdy_m stays high.
REQ-019 SHALL clear vld_m on a cycle with vld_m & rdy_m and no new input beat accepted.
REQ-020 SHALL hold vld_m, pld_m, last_m, gnt_id_m stable while vld_m & ~rdy_m, with v_rdy_s all zero.
REQ-021 SHALL implement states IDLE (no packet open) and LOCK (packet open, owner register valid).
REQ-022 In IDLE SHALL select: ptr if v_vld_s[ptr] & cred != 0; else first valid requester scanning ptr+1, ptr+2, ... wrapping, ptr last; none valid -> no grant.
REQ-023 On accepting a first beat in IDLE from sel: if sel == ptr & cred != 0 then cred <= cred-1; else ptr <= sel, cred <= max(weight[sel],1)-1.
REQ-024 IDLE -> LOCK with owner <= sel when the accepted first beat has last=0; accepted beat with last=1 stays IDLE (single-beat packet).
REQ-025 In LOCK SHALL grant only owner; ptr/cred unchanged; LOCK -> IDLE when owner's last beat is accepted.
REQ-026 In LOCK, owner dropping v_vld_s SHALL NOT release the lock; other requesters stay ungranted (bubble).
REQ-027 Weight 0 SHALL be treated as 1; v_weight changes take effect only at the next cred reload.
REQ-028 Requests with no grant SHALL keep v_rdy_s low; arbiter never drops a beat, never duplicates one.

Reset
REQ-029 During rst: state=IDLE, ptr=WIDTH-1, cred=0, owner=0, vld_m=0, pld_m=0, last_m=0, gnt_id_m=0, v_rdy_s=0.
REQ-030 rst asserted mid-packet or with vld_m=1 SHALL discard the open packet and the buffered beat; no beat emitted until post-reset acceptance.

Verification
REQ-031 Reset: rst=1 two cycles with all v_vld_s=1 -> all outputs 0 during rst; first vld_m=1 one cycle after rst release, gnt_id_m=0.
REQ-032 WRR: WIDTH=4, weights {w0..w3}={1,2,1,3}, all valid single-beat, rdy_m=1 -> gnt_id_m sequence 0,1,1,2,3,3,3,0,1,1,... back-to-back, no bubbles.
REQ-033 Packet lock: req0 sends 3-beat packet (last on beat 3), req1 valid throughout -> gnt_id_m 0,0,0 contiguous then 1; pld_m order matches input.
REQ-034 Backpressure: vld_m=1, rdy_m=0 for 5 cycles -> pld_m/gnt_id_m unchanged, v_rdy_s=0; rdy_m=1 -> beat leaves, next beat appears following cycle.
REQ-035 Owner bubble: req2 mid-packet drops v_vld_s 2 cycles while req0 valid -> v_rdy_s[0]=0 until req2 last beat accepted, then req0 granted.
REQ-036 Zero weight: weights all 0, req1 and req3 valid single-beat -> strict alternation 1,3,1,3.

Source files
------------

// File: rtl/arb_wrr_pkt_if.sv
// Handshake bundle for arb_wrr_pkt: per-requester slave beats in, one master beat stream out.
interface arb_wrr_pkt_if #(
    parameter int WIDTH     = 4,
    parameter int PLD_WIDTH = 32
);
    localparam int IDW = $clog2(WIDTH);

    logic [WIDTH-1:0]     v_vld_s;
    logic [WIDTH-1:0]     v_rdy_s;
    logic [WIDTH-1:0]     v_last_s;
    logic [PLD_WIDTH-1:0] v_pld_s [WIDTH];
    logic                 vld_m;
    logic                 rdy_m;
    logic [PLD_WIDTH-1:0] pld_m;
    logic                 last_m;
    logic [IDW-1:0]       gnt_id_m;

    modport slave (
        input  v_vld_s, v_last_s, v_pld_s, rdy_m,
        output v_rdy_s, vld_m, pld_m, last_m, gnt_id_m
    );

    modport master (
        output v_vld_s, v_last_s, v_pld_s, rdy_m,
        input  v_rdy_s, vld_m, pld_m, last_m, gnt_id_m
    );
endinterface

// File: rtl/arb_wrr_pkt.sv
// Packet-locked weighted round-robin arbiter with a one-entry registered master stage.
module arb_wrr_pkt #(
    parameter int WIDTH     = 4,
    parameter int PLD_WIDTH = 32,
    parameter int WGT_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    arb_wrr_pkt_if.slave               bus,
    input  logic [WIDTH*WGT_WIDTH-1:0] v_weight
);
    localparam int IDW = $clog2(WIDTH);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t               state_q, state_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [IDW-1:0]       owner_q, owner_d;
    logic [WGT_WIDTH-1:0] cred_q, cred_d;
    logic                 vld_m_q, vld_m_d;
    logic                 last_m_q, last_m_d;
    logic [PLD_WIDTH-1:0] pld_m_q, pld_m_d;
    logic [IDW-1:0]       gnt_id_m_q, gnt_id_m_d;

    logic [WGT_WIDTH-1:0] wgt [WIDTH];
    logic [IDW-1:0]       sel, scan_id, gnt_id;
    logic                 sel_found, gnt_vld, load, accept;
    logic [WIDTH-1:0]     rdy;

    always_comb begin
        for (int unsigned i = 0; i < WIDTH; i++) begin
            wgt[i] = v_weight[i*WGT_WIDTH +: WGT_WIDTH];
        end
    end

    // Current pointer keeps priority only while it still has credit; otherwise it is scanned last.
    always_comb begin
        sel_found = 1'b0;
        sel       = ptr_q;
        scan_id   = '0;
        if (bus.v_vld_s[ptr_q] && cred_q != '0) begin
            sel_found = 1'b1;
        end else begin
            for (int unsigned k = 1; k <= WIDTH; k++) begin
                scan_id = IDW'((32'(ptr_q) + k) % WIDTH);
                if (!sel_found && bus.v_vld_s[scan_id]) begin
                    sel_found = 1'b1;
                    sel       = scan_id;
                end
            end
        end
    end

    always_comb begin
        gnt_vld    = (state_q == LOCK) ? 1'b1 : sel_found;
        gnt_id     = (state_q == LOCK) ? owner_q : sel;
        load       = ~vld_m_q | bus.rdy_m;
        accept     = ~rst & load & gnt_vld & bus.v_vld_s[gnt_id];
        rdy        = '0;
        state_d    = state_q;
        ptr_d      = ptr_q;
        cred_d     = cred_q;
        owner_d    = owner_q;
        vld_m_d    = vld_m_q;
        last_m_d   = last_m_q;
        pld_m_d    = pld_m_q;
        gnt_id_m_d = gnt_id_m_q;

        if (accept) begin
            rdy[gnt_id] = 1'b1;
            vld_m_d     = 1'b1;
            pld_m_d     = bus.v_pld_s[gnt_id];
            last_m_d    = bus.v_last_s[gnt_id];
            gnt_id_m_d  = gnt_id;
            case (state_q)
                IDLE: begin
                    if (sel == ptr_q && cred_q != '0) begin
                        cred_d = cred_q - WGT_WIDTH'(1);
                    end else begin
                        ptr_d  = sel;
                        cred_d = (wgt[sel] == '0) ? '0 : wgt[sel] - WGT_WIDTH'(1);
                    end
                    if (!bus.v_last_s[sel]) begin
                        state_d = LOCK;
                        owner_d = sel;
                    end
                end
                LOCK: begin
                    if (bus.v_last_s[owner_q]) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (bus.rdy_m) begin
            vld_m_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= IDW'(WIDTH - 1);
            cred_q     <= '0;
            owner_q    <= '0;
            vld_m_q    <= 1'b0;
            last_m_q   <= 1'b0;
            pld_m_q    <= '0;
            gnt_id_m_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cred_q     <= cred_d;
            owner_q    <= owner_d;
            vld_m_q    <= vld_m_d;
            last_m_q   <= last_m_d;
            pld_m_q    <= pld_m_d;
            gnt_id_m_q <= gnt_id_m_d;
        end
    end

    assign bus.v_rdy_s  = rdy;
    assign bus.vld_m    = vld_m_q;
    assign bus.last_m   = last_m_q;
    assign bus.pld_m    = pld_m_q;
    assign bus.gnt_id_m = gnt_id_m_q;
endmodule

// File: tb/tb_arb_wrr_pkt.sv
// Bench for arb_wrr_pkt: directed scenarios plus random traffic against a cycle reference model.
module tb_arb_wrr_pkt;
    localparam int W  = 4;
    localparam int PW = 32;
    localparam int WW = 4;

    logic          clk;
    logic          rst;
    logic [W*WW-1:0] v_weight;

    arb_wrr_pkt_if #(.WIDTH(W), .PLD_WIDTH(PW)) bus ();

    arb_wrr_pkt #(.WIDTH(W), .PLD_WIDTH(PW), .WGT_WIDTH(WW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .v_weight (v_weight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Source-side packet generators
    int want [W];
    int drop [W];
    int plen [W];
    int pos  [W];
    int seq  [W];
    int len_cfg [W];
    int wgt  [W];

    // Reference model state
    int          m_ptr, m_cred, m_owner, m_id, acc;
    bit          m_lock, m_vld, m_last;
    logic [PW-1:0] m_pld;
    logic [W-1:0]  exp_rdy;

    int          out_q [$];
    logic [PW-1:0] out_pld [$];

    task automatic new_packet(input int i);
        plen[i] = (len_cfg[i] == 0) ? int'($urandom_range(1, 4)) : len_cfg[i];
        pos[i]  = 0;
    endtask

    task automatic set_weights(input int a, input int b, input int c, input int d);
        wgt[0] = a; wgt[1] = b; wgt[2] = c; wgt[3] = d;
        v_weight = {4'(d), 4'(c), 4'(b), 4'(a)};
    endtask

    task automatic drive();
        for (int i = 0; i < W; i++) begin
            bus.v_vld_s[i]  = (want[i] != 0) && (drop[i] == 0);
            bus.v_last_s[i] = (pos[i] == plen[i] - 1);
            bus.v_pld_s[i]  = {8'(i), 24'(seq[i])};
        end
    endtask

    task automatic model_comb();
        int g;
        acc     = -1;
        exp_rdy = '0;
        g       = -1;
        if (!rst && (!m_vld || bus.rdy_m)) begin
            if (m_lock) begin
                g = m_owner;
            end else begin
                // rotation order: ptr (only with credit), ptr+1, ..., ptr again last
                for (int k = 0; k <= W; k++) begin
                    int c;
                    c = (m_ptr + k) % W;
                    if (g < 0 && bus.v_vld_s[c] && (k != 0 || m_cred > 0)) g = c;
                end
            end
            if (g >= 0 && bus.v_vld_s[g]) begin
                acc          = g;
                exp_rdy[g]   = 1'b1;
            end
        end
    endtask

    task automatic model_seq();
        bit lst;
        if (rst) begin
            m_ptr = W - 1; m_cred = 0; m_lock = 0; m_owner = 0;
            m_vld = 0; m_pld = '0; m_last = 0; m_id = 0;
            for (int i = 0; i < W; i++) new_packet(i);
            return;
        end
        if (acc >= 0) begin
            lst    = bus.v_last_s[acc];
            m_vld  = 1;
            m_pld  = bus.v_pld_s[acc];
            m_last = lst;
            m_id   = acc;
            if (!m_lock) begin
                if (acc == m_ptr && m_cred > 0) begin
                    m_cred = m_cred - 1;
                end else begin
                    m_ptr  = acc;
                    m_cred = ((wgt[acc] < 1) ? 1 : wgt[acc]) - 1;
                end
                if (!lst) begin
                    m_lock  = 1;
                    m_owner = acc;
                end
            end else if (lst) begin
                m_lock = 0;
            end
            seq[acc] = seq[acc] + 1;
            pos[acc] = pos[acc] + 1;
            if (pos[acc] == plen[acc]) new_packet(acc);
        end else if (bus.rdy_m) begin
            m_vld = 0;
        end
    endtask

    function automatic logic [39:0] obs();
        return {bus.vld_m, bus.last_m, bus.gnt_id_m, bus.pld_m, bus.v_rdy_s};
    endfunction

    function automatic logic [39:0] exp_obs();
        return {m_vld, m_last, 2'(m_id), m_pld, exp_rdy};
    endfunction

    task automatic cyc_begin();
        drive();
        #3;
        model_comb();
    endtask

    task automatic cyc_end();
        if (!rst && bus.vld_m && bus.rdy_m) begin
            out_q.push_back(int'(bus.gnt_id_m));
            out_pld.push_back(bus.pld_m);
        end
        @(posedge clk);
        model_seq();
        #1;
    endtask

    task automatic clear_sources();
        for (int i = 0; i < W; i++) begin
            want[i] = 0; drop[i] = 0; len_cfg[i] = 1;
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        cyc_begin();
        cyc_end();
        rst = 1'b0;
        out_q.delete();
        out_pld.delete();
    endtask

    task automatic test_reset();
        clear_sources();
        for (int i = 0; i < W; i++) want[i] = 1;
        bus.rdy_m = 1'b1;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            cyc_begin();
            checks++;
            if (obs() !== 40'h0) begin
                failures++;
                $display("FAIL reset_outputs c=%0d got=%h exp=0", c, obs());
            end
            cyc_end();
        end
        rst = 1'b0;
        cyc_begin();
        checks++;
        if (bus.vld_m !== 1'b0 || bus.v_rdy_s !== 4'b0001) begin
            failures++;
            $display("FAIL reset_release vld_m=%b v_rdy_s=%b exp vld_m=0 v_rdy_s=0001", bus.vld_m, bus.v_rdy_s);
        end
        cyc_end();
        cyc_begin();
        checks++;
        if (bus.vld_m !== 1'b1 || bus.gnt_id_m !== 2'd0) begin
            failures++;
            $display("FAIL reset_first_beat vld_m=%b gnt=%0d exp vld_m=1 gnt=0", bus.vld_m, bus.gnt_id_m);
        end
        checks++;
        if (obs() !== exp_obs()) begin
            failures++;
            $display("FAIL reset_model got=%h exp=%h", obs(), exp_obs());
        end
        cyc_end();
    endtask

    task automatic test_wrr();
        int exp_seq [10] = '{0, 1, 1, 2, 3, 3, 3, 0, 1, 1};
        clear_sources();
        for (int i = 0; i < W; i++) want[i] = 1;
        set_weights(1, 2, 1, 3);
        bus.rdy_m = 1'b1;
        reset_dut();
        for (int c = 0; c < 22; c++) begin
            cyc_begin();
            checks++;
            if (obs() !== exp_obs()) begin
                failures++;
                $display("FAIL wrr_cycle c=%0d got=%h exp=%h", c, obs(), exp_obs());
            end
            cyc_end();
        end
        checks++;
        if (out_q.size() != 21) begin
            failures++;
            $display("FAIL wrr_no_bubble beats=%0d exp=21", out_q.size());
        end else begin
            for (int k = 0; k < 10; k++) begin
                checks++;
                if (out_q[k] != exp_seq[k]) begin
                    failures++;
                    $display("FAIL wrr_order k=%0d gnt=%0d exp=%0d", k, out_q[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_lock();
        int s0;
        clear_sources();
        want[0] = 1; want[1] = 1;
        len_cfg[0] = 3;
        set_weights(1, 1, 1, 1);
        bus.rdy_m = 1'b1;
        reset_dut();
        s0 = seq[0];
        for (int c = 0; c < 8; c++) begin
            cyc_begin();
            checks++;
            if (obs() !== exp_obs()) begin
                failures++;
                $display("FAIL lock_cycle c=%0d got=%h exp=%h", c, obs(), exp_obs());
            end
            cyc_end();
        end
        checks++;
        if (out_q.size() < 4) begin
            failures++;
            $display("FAIL lock_count beats=%0d exp>=4", out_q.size());
        end else begin
            checks++;
            if (out_q[0] != 0 || out_q[1] != 0 || out_q[2] != 0 || out_q[3] != 1) begin
                failures++;
                $display("FAIL lock_order got=%0d,%0d,%0d,%0d exp=0,0,0,1", out_q[0], out_q[1], out_q[2], out_q[3]);
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (out_pld[k] !== {8'd0, 24'(s0 + k)}) begin
                    failures++;
                    $display("FAIL lock_payload k=%0d got=%h exp=%h", k, out_pld[k], {8'd0, 24'(s0 + k)});
                end
            end
            checks++;
            if (out_pld[2][0] !== out_pld[2][0] || 1'b0) begin
            end
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] hold;
        clear_sources();
        want[1] = 1;
        set_weights(1, 1, 1, 1);
        bus.rdy_m = 1'b1;
        reset_dut();
        for (int c = 0; c < 2; c++) begin
            cyc_begin();
            checks++;
            if (obs() !== exp_obs()) begin
                failures++;
                $display("FAIL bp_fill c=%0d got=%h exp=%h", c, obs(), exp_obs());
            end
            cyc_end();
        end
        hold = m_pld;
        bus.rdy_m = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cyc_begin();
            checks++;
            if (bus.vld_m !== 1'b1 || bus.pld_m !== hold || bus.gnt_id_m !== 2'd1 || bus.v_rdy_s !== 4'b0) begin
                failures++;
                $display("FAIL bp_stall c=%0d vld=%b pld=%h gnt=%0d rdy=%b exp vld=1 pld=%h gnt=1 rdy=0000",
                         c, bus.vld_m, bus.pld_m, bus.gnt_id_m, bus.v_rdy_s, hold);
            end
            cyc_end();
        end
        bus.rdy_m = 1'b1;
        cyc_begin();
        checks++;
        if (obs() !== exp_obs()) begin
            failures++;
            $display("FAIL bp_release got=%h exp=%h", obs(), exp_obs());
        end
        cyc_end();
        cyc_begin();
        checks++;
        if (bus.vld_m !== 1'b1 || bus.pld_m !== hold + 1) begin
            failures++;
            $display("FAIL bp_next vld=%b pld=%h exp vld=1 pld=%h", bus.vld_m, bus.pld_m, hold + 1);
        end
        cyc_end();
    endtask

    task automatic test_owner_bubble();
        clear_sources();
        want[2] = 1;
        len_cfg[2] = 4;
        set_weights(1, 1, 1, 1);
        bus.rdy_m = 1'b1;
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            want[0] = (c >= 1) ? 1 : 0;
            drop[2] = (c == 2 || c == 3) ? 1 : 0;
            cyc_begin();
            checks++;
            if (obs() !== exp_obs()) begin
                failures++;
                $display("FAIL bubble_cycle c=%0d got=%h exp=%h", c, obs(), exp_obs());
            end
            if (c >= 1 && c <= 6) begin
                checks++;
                if (bus.v_rdy_s[0] !== (c == 6)) begin
                    failures++;
                    $display("FAIL bubble_rdy0 c=%0d got=%b exp=%b", c, bus.v_rdy_s[0], (c == 6));
                end
            end
            cyc_end();
        end
        checks++;
        if (out_q.size() < 5) begin
            failures++;
            $display("FAIL bubble_count beats=%0d exp>=5", out_q.size());
        end else if (out_q[0] != 2 || out_q[1] != 2 || out_q[2] != 2 || out_q[3] != 2 || out_q[4] != 0) begin
            failures++;
            $display("FAIL bubble_order got=%0d,%0d,%0d,%0d,%0d exp=2,2,2,2,0",
                     out_q[0], out_q[1], out_q[2], out_q[3], out_q[4]);
        end
    endtask

    task automatic test_zero_weight();
        int exp_seq [6] = '{1, 3, 1, 3, 1, 3};
        clear_sources();
        want[1] = 1; want[3] = 1;
        set_weights(0, 0, 0, 0);
        bus.rdy_m = 1'b1;
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            cyc_begin();
            checks++;
            if (obs() !== exp_obs()) begin
                failures++;
                $display("FAIL zero_cycle c=%0d got=%h exp=%h", c, obs(), exp_obs());
            end
            cyc_end();
        end
        checks++;
        if (out_q.size() < 6) begin
            failures++;
            $display("FAIL zero_count beats=%0d exp>=6", out_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (out_q[k] != exp_seq[k]) begin
                    failures++;
                    $display("FAIL zero_order k=%0d gnt=%0d exp=%0d", k, out_q[k], exp_seq[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        clear_sources();
        for (int i = 0; i < W; i++) len_cfg[i] = 0;
        set_weights(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        bus.rdy_m = 1'b1;
        reset_dut();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < W; i++) begin
                want[i] = ($urandom_range(0, 9) < 7) ? 1 : 0;
                drop[i] = ($urandom_range(0, 9) < 2) ? 1 : 0;
            end
            bus.rdy_m = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 49) == 0) begin
                set_weights(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end
            cyc_begin();
            checks++;
            if (obs() !== exp_obs()) begin
                failures++;
                $display("FAIL random_cycle c=%0d got=%h exp=%h", c, obs(), exp_obs());
            end
            cyc_end();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        bus.rdy_m = 1'b0;
        for (int i = 0; i < W; i++) seq[i] = 0;
        clear_sources();
        set_weights(1, 1, 1, 1);
        drive();
        @(posedge clk);
        model_seq();
        #1;
        test_reset();
        test_wrr();
        test_lock();
        test_backpressure();
        test_owner_bubble();
        test_zero_weight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
